seq_arith_unit: RTL

Second-generation signed arithmetic unit for the ALU datapath.
- Parametrised operand and result widths.
- ADD, SUB and MUL complete in one cycle.
- DIV is a multi-cycle iterative divider that returns both quotient and remainder.
- Adds a busy handshake, signed-overflow and divide-by-zero status, and a registered one-cycle result-valid pulse.

---
 rtl/seq_arith_unit.sv | 135 +++++++++++++
 1 files changed

// File: rtl/seq_arith_unit.sv
// seq_arith_unit: signed ADD/SUB/MUL in one cycle, iterative restoring DIV with quotient and remainder.
// Define ARITH_SAT_EN to saturate arith_out to the in_width signed range on overflow.
module seq_arith_unit #(
    parameter int in_width  = 8,
    parameter int out_width = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [in_width-1:0]  a,
    input  logic [in_width-1:0]  b,
    input  logic                 arith_enable,
    input  logic [1:0]           alu_func_arith,
    output logic                 busy,
    output logic [out_width-1:0] arith_out,
    output logic [in_width-1:0]  remainder,
    output logic                 carry_out,
    output logic                 overflow,
    output logic                 div_by_zero,
    output logic                 arith_flag
);
    localparam int cw = $clog2(in_width + 1);

    typedef enum logic {IDLE, DIV_RUN} state_t;

    state_t               state;
    logic [in_width-1:0]  dvs, quo, quo_nx, rem, rem_nx, r_res;
    logic [in_width:0]    shifted, trial;
    logic [cw-1:0]        cnt;
    logic [out_width-1:0] hi, lo, ax, bx, fast_res, fast_out, q_res, q_out;
    logic                 q_neg, r_neg, fast_ovf, q_ovf, add_c, sub_c;

    function automatic logic [out_width-1:0] sext(input logic [in_width-1:0] v);
        return {{(out_width-in_width){v[in_width-1]}}, v};
    endfunction

    function automatic logic [out_width-1:0] zext(input logic [in_width-1:0] v);
        return {{(out_width-in_width){1'b0}}, v};
    endfunction

    function automatic logic [in_width-1:0] mag(input logic [in_width-1:0] v);
        return v[in_width-1] ? -v : v;
    endfunction

    function automatic logic out_of_range(input logic [out_width-1:0] v, h, l);
        return $signed(v) > $signed(h) || $signed(v) < $signed(l);
    endfunction

    // Low out_width bits of the product are sign-agnostic, so a plain multiply of the extended operands is exact.
    always_comb begin
        hi       = zext({1'b0, {(in_width-1){1'b1}}});
        lo       = ~hi;
        ax       = sext(a);
        bx       = sext(b);
        add_c    = in_width'(a + b) < a;
        sub_c    = a < b;
        fast_res = alu_func_arith == 2'b00 ? ax + bx :
                   alu_func_arith == 2'b01 ? ax - bx : ax * bx;
        fast_ovf = out_of_range(fast_res, hi, lo);
        shifted  = {rem, quo[in_width-1]};
        trial    = shifted - {1'b0, dvs};
        quo_nx   = {quo[in_width-2:0], ~trial[in_width]};
        rem_nx   = trial[in_width] ? shifted[in_width-1:0] : trial[in_width-1:0];
        q_res    = q_neg ? -zext(quo_nx) : zext(quo_nx);
        r_res    = r_neg ? -rem_nx : rem_nx;
        q_ovf    = out_of_range(q_res, hi, lo);
`ifdef ARITH_SAT_EN
        fast_out = fast_ovf ? (fast_res[out_width-1] ? lo : hi) : fast_res;
        q_out    = q_ovf ? (q_res[out_width-1] ? lo : hi) : q_res;
`else
        fast_out = fast_res;
        q_out    = q_res;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            arith_out   <= '0;
            remainder   <= '0;
            carry_out   <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            arith_flag  <= 1'b0;
            dvs         <= '0;
            quo         <= '0;
            rem         <= '0;
            cnt         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
        end else begin
            arith_flag <= 1'b0;
            if (state == DIV_RUN) begin
                quo <= quo_nx;
                rem <= rem_nx;
                cnt <= cnt + 1'b1;
                if (cnt == cw'(in_width - 1)) begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    arith_flag  <= 1'b1;
                    arith_out   <= q_out;
                    remainder   <= r_res;
                    overflow    <= q_ovf;
                    carry_out   <= 1'b0;
                    div_by_zero <= 1'b0;
                end
            end else if (arith_enable) begin
                if (alu_func_arith == 2'b11 && b != '0) begin
                    state <= DIV_RUN;
                    busy  <= 1'b1;
                    dvs   <= mag(b);
                    quo   <= mag(a);
                    rem   <= '0;
                    cnt   <= '0;
                    q_neg <= a[in_width-1] ^ b[in_width-1];
                    r_neg <= a[in_width-1];
                end else if (alu_func_arith == 2'b11) begin
                    arith_flag  <= 1'b1;
                    arith_out   <= '1;
                    remainder   <= a;
                    carry_out   <= 1'b0;
                    overflow    <= 1'b0;
                    div_by_zero <= 1'b1;
                end else begin
                    arith_flag  <= 1'b1;
                    arith_out   <= fast_out;
                    remainder   <= '0;
                    carry_out   <= alu_func_arith == 2'b00 ? add_c : alu_func_arith == 2'b01 && sub_c;
                    overflow    <= fast_ovf;
                    div_by_zero <= 1'b0;
                end
            end
        end
    end
endmodule
